retire_wide: RTL and testbench
==============================

// Module: retire_wide
// PURPOSE
//  Parametrised in-order commit stage; successor of the single-wide retire stage.
//  - Retires up to RETIRE_WIDTH ready ROB head entries per cycle.
//  - Serialises stores to memory through a req/ack handshake.
//  - Issues registered pipeline flushes for mispredicted branches and JALR.
//  - Sits between the ROB/LSQ heads and the register file, map table and data memory.
// PARAMETERS
//  RETIRE_WIDTH  2   max instructions committed per cycle (1..4)
//  CNT_W         32  width of the retired-instruction performance counter
// PORTS
//  clk            in   1          clock; all state updates on rising edge
//  reset          in   1          synchronous, active-low reset (asserted when 0)
//  rob_head       in   W x rob_entry   ROB entries head..head+W-1
//  rob_valid      in   W          slot i holds an allocated entry
//  lsq_head       in   lsq_entry  oldest LSQ entry
//  retire_stall   in   1          global hold: no new commits this cycle
//  st_ack         in   1          memory accepted current store
//  regwr          out  W          per-slot register write enable
//  rd             out  W x Register     per-slot destination
//  value          out  W x MemoryWord   per-slot writeback value
//  re             out  W x rob_entry    per-slot retired entry (map-table free)
//  victim         out  W          slot i frees an old physical mapping
//  rob_decrement  out  $clog2(W+1)  number of ROB entries retired
//  le             out  lsq_entry  store being written
//  le_size        out  int        store bytes: SB 1, SH 2, SW 4, SD 8
//  st_req         out  1          store request, held until st_ack
//  lsq_decrement  out  1          pop LSQ head (one-cycle pulse)
//  flush          out  1          one-cycle flush pulse
//  jump_to        out  Address    redirect PC, valid with flush
//  retired_count  out  CNT_W      total instructions retired, saturating
// BEHAVIOUR
//  - Outputs are registered: a decision made in cycle N is visible in cycle N+1.
//  - Reset (reset==0 at edge): every output is 0, state is RUN, retired_count is 0.
//  - Reset mid-store drops st_req without waiting for st_ack.
//  - FSM:
//    - RUN: select slots.
//      - Slot i commits iff slots 0..i-1 commit, rob_valid[i], rob_head[i].ready,
//        and no earlier slot this cycle is a store or a flush source.
//      - A store slot additionally requires rob_head[i].tag == lsq_head.tag.
//      - A store commits all slots up to and including itself; go to STORE.
//      - A flush source ends the group; go to FLUSH.
//    - STORE: st_req=1 and le/le_size stay stable.
//      - rob_decrement stays 0 while waiting.
//      - On the st_ack cycle, the next cycle gives lsq_decrement=1, st_req=0, back to RUN.
//    - FLUSH: flush=1 with jump_to for exactly one cycle.
//      - No commits in that cycle; back to RUN next cycle.
//  - Flush sources:
//    - JALR (regwr & ucjump & alusrc): jump_to = value, written value = pc+4.
//    - Mispredicted branch (cjump & ctrl_bits.flush): jump_to = prediction ? pc+4 : value.
//  - Writeback:
//    - value forced to 0 when rd==0.
//    - victim[i] = commit[i] & regwr.
//    - Uncommitted slots drive regwr/re/victim = 0.
//  - Commit decisions in RUN use the slot flags in the commit rule above.
//    - Register writes of a store group appear with the store's st_req; the ROB pops on the ack.
//  - retire_stall=1 in RUN: no commits, state held.
//    - In STORE the handshake still completes; in FLUSH the pulse is still emitted.
//  - rob_decrement equals the number of committed slots, up to RETIRE_WIDTH.
//    - It is never nonzero in the same cycle as flush for younger slots.
//  - retired_count adds rob_decrement each cycle and saturates at all-ones.
// TESTING
//  - W=2: two ready ALU ops rd=3,4 -> next cycle regwr=2'b11, rob_decrement=2, count=2.
//  - Slot0 not ready, slot1 ready -> regwr=0 and rob_decrement=0 (in-order).
//  - SW at slot0, tag matches lsq; st_ack after 3 cycles ->
//    st_req high for 3 cycles, le_size=4, then lsq_decrement pulse 1 cycle, then RUN.
//  - Mispredicted branch slot0, prediction=1, pc=0x100 + ALU op slot1 ->
//    flush=1, jump_to=0x104, rob_decrement=1, slot1 not written.
//  - JALR rd=1, value=0x200, pc=0x40 -> value=0x44, jump_to=0x200, flush one cycle.
//  - reset=0 while st_req high -> next cycle all outputs 0, no lsq_decrement.

Source files
------------

// File: rtl/retire_wide_if.sv
// retire_wide_if: ROB/LSQ head, writeback, store and flush signals of the commit stage.
package retire_wide_pkg;
  typedef logic [4:0] reg_t;
  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;
  typedef struct packed { logic flush; } ctrl_t;
  typedef struct packed {
    logic ready;
    logic [3:0] tag;
    addr_t pc;
    word_t value;
    reg_t rd;
    logic regwr;
    logic ucjump;
    logic alusrc;
    logic cjump;
    logic prediction;
    logic store;
    ctrl_t ctrl_bits;
  } rob_entry_t;
  typedef struct packed {
    logic [3:0] tag;
    addr_t addr;
    word_t data;
    logic [1:0] size;
  } lsq_entry_t;
endpackage

interface retire_wide_if import retire_wide_pkg::*; #(parameter int W = 2, parameter int CNT_W = 32);
  rob_entry_t [W-1:0] rob_head;
  logic [W-1:0] rob_valid;
  lsq_entry_t lsq_head;
  logic retire_stall;
  logic st_ack;
  logic [W-1:0] regwr;
  reg_t [W-1:0] rd;
  word_t [W-1:0] value;
  rob_entry_t [W-1:0] re;
  logic [W-1:0] victim;
  logic [$clog2(W+1)-1:0] rob_decrement;
  lsq_entry_t le;
  int le_size;
  logic st_req;
  logic lsq_decrement;
  logic flush;
  addr_t jump_to;
  logic [CNT_W-1:0] retired_count;
  modport master (
    input rob_head, rob_valid, lsq_head, retire_stall, st_ack,
    output regwr, rd, value, re, victim, rob_decrement, le, le_size,
    st_req, lsq_decrement, flush, jump_to, retired_count
  );
  modport slave (
    output rob_head, rob_valid, lsq_head, retire_stall, st_ack,
    input regwr, rd, value, re, victim, rob_decrement, le, le_size,
    st_req, lsq_decrement, flush, jump_to, retired_count
  );
endinterface

// File: rtl/retire_wide.sv
// retire_wide: in-order commit of up to RETIRE_WIDTH ROB heads, store handshake and flush redirect.
module retire_wide import retire_wide_pkg::*; #(
  parameter int RETIRE_WIDTH = 2,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  retire_wide_if.master bus
);
  localparam int W = RETIRE_WIDTH;
  localparam int DW = $clog2(W + 1);
  typedef enum logic [1:0] {RUN, STORE, FLUSH} state_t;
  state_t state_q, state_d;
  logic [W-1:0] regwr_q, regwr_d, victim_q, victim_d;
  reg_t [W-1:0] rd_q, rd_d;
  word_t [W-1:0] value_q, value_d;
  rob_entry_t [W-1:0] re_q, re_d;
  logic [DW-1:0] dec_q, dec_d, pend_q, pend_d;
  lsq_entry_t le_q, le_d;
  int le_size_q, le_size_d;
  logic st_req_q, st_req_d, lsq_dec_q, lsq_dec_d, flush_q, flush_d;
  addr_t jump_q, jump_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0] sum;
  always_comb begin
    rob_entry_t e;
    logic go, jalr, br;
    e = '0;
    jalr = 1'b0;
    br = 1'b0;
    state_d = state_q;
    pend_d = pend_q;
    regwr_d = '0;
    victim_d = '0;
    rd_d = '0;
    value_d = '0;
    re_d = '0;
    dec_d = '0;
    le_d = '0;
    le_size_d = 0;
    st_req_d = 1'b0;
    lsq_dec_d = 1'b0;
    flush_d = 1'b0;
    jump_d = '0;
    go = state_q == RUN && !bus.retire_stall;
    for (int i = 0; i < W; i++) begin
      e = bus.rob_head[i];
      jalr = e.regwr & e.ucjump & e.alusrc;
      br = e.cjump & e.ctrl_bits.flush;
      go = go & bus.rob_valid[i] & e.ready & (!e.store | e.tag == bus.lsq_head.tag);
      if (go) begin
        regwr_d[i] = e.regwr;
        victim_d[i] = e.regwr;
        rd_d[i] = e.rd;
        value_d[i] = e.rd == '0 ? '0 : jalr ? e.pc + 32'd4 : e.value;
        re_d[i] = e;
        dec_d = DW'(i + 1);
        if (e.store) begin
          state_d = STORE;
          st_req_d = 1'b1;
          le_d = bus.lsq_head;
          le_size_d = 32'd1 << bus.lsq_head.size;
        end else if (jalr | br) begin
          state_d = FLUSH;
          flush_d = 1'b1;
          jump_d = jalr ? e.value : e.prediction ? e.pc + 32'd4 : e.value;
        end
      end
      go = go & !e.store & !jalr & !br;
    end
    // a store group's ROB pop is deferred until memory acknowledges the store
    if (st_req_d) begin
      pend_d = dec_d;
      dec_d = '0;
    end
    if (state_q == STORE) begin
      st_req_d = !bus.st_ack;
      lsq_dec_d = bus.st_ack;
      le_d = bus.st_ack ? '0 : le_q;
      le_size_d = bus.st_ack ? 0 : le_size_q;
      dec_d = bus.st_ack ? pend_q : '0;
      state_d = bus.st_ack ? RUN : STORE;
    end
    if (state_q == FLUSH) state_d = RUN;
    sum = {1'b0, cnt_q} + (CNT_W + 1)'(dec_d);
    cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      pend_q <= '0;
      regwr_q <= '0;
      victim_q <= '0;
      rd_q <= '0;
      value_q <= '0;
      re_q <= '0;
      dec_q <= '0;
      le_q <= '0;
      le_size_q <= 0;
      st_req_q <= 1'b0;
      lsq_dec_q <= 1'b0;
      flush_q <= 1'b0;
      jump_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      regwr_q <= regwr_d;
      victim_q <= victim_d;
      rd_q <= rd_d;
      value_q <= value_d;
      re_q <= re_d;
      dec_q <= dec_d;
      le_q <= le_d;
      le_size_q <= le_size_d;
      st_req_q <= st_req_d;
      lsq_dec_q <= lsq_dec_d;
      flush_q <= flush_d;
      jump_q <= jump_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.regwr = regwr_q;
  assign bus.victim = victim_q;
  assign bus.rd = rd_q;
  assign bus.value = value_q;
  assign bus.re = re_q;
  assign bus.rob_decrement = dec_q;
  assign bus.le = le_q;
  assign bus.le_size = le_size_q;
  assign bus.st_req = st_req_q;
  assign bus.lsq_decrement = lsq_dec_q;
  assign bus.flush = flush_q;
  assign bus.jump_to = jump_q;
  assign bus.retired_count = cnt_q;
endmodule

// File: tb/tb_retire_wide.sv
// tb_retire_wide: directed commit scenarios checked through a per-cycle expectation scoreboard.
module tb_retire_wide;
  import retire_wide_pkg::*;
  typedef struct packed {
    logic [1:0] regwr;
    logic [1:0] victim;
    logic [1:0] dec;
    logic st_req;
    logic lsq_dec;
    logic flush;
    logic [31:0] jump;
    logic [31:0] le_size;
    logic [4:0] rd0;
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  rob_entry_t st, br, j;
  exp_t x, y;
  always #5 clk = ~clk;
  retire_wide_if #(.W(2), .CNT_W(4)) bus();
  retire_wide #(.RETIRE_WIDTH(2), .CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic rob_entry_t alu(input reg_t rd, input word_t v);
    rob_entry_t e = '0;
    e.ready = 1'b1;
    e.regwr = 1'b1;
    e.rd = rd;
    e.value = v;
    return e;
  endfunction
  function automatic exp_t wb(input logic [1:0] w, input logic [1:0] d, input reg_t r0, input word_t a, input word_t b);
    exp_t e = '0;
    e.regwr = w;
    e.victim = w;
    e.dec = d;
    e.rd0 = r0;
    e.v0 = a;
    e.v1 = b;
    return e;
  endfunction
  task automatic cyc(input exp_t xin);
    exp_t e;
    exp_cnt = !reset ? 0 : (exp_cnt + int'(xin.dec) > 15 ? 15 : exp_cnt + int'(xin.dec));
    xin.cnt = exp_cnt;
    sb.push_back(xin);
    @(negedge clk);
    e = sb.pop_front();
    check("regwr", 32'(bus.regwr), 32'(e.regwr));
    check("victim", 32'(bus.victim), 32'(e.victim));
    check("rob_decrement", 32'(bus.rob_decrement), 32'(e.dec));
    check("st_req", 32'(bus.st_req), 32'(e.st_req));
    check("lsq_decrement", 32'(bus.lsq_decrement), 32'(e.lsq_dec));
    check("flush", 32'(bus.flush), 32'(e.flush));
    check("retired_count", 32'(bus.retired_count), e.cnt);
    if (e.regwr[0]) check("rd0", 32'(bus.rd[0]), 32'(e.rd0));
    if (e.regwr[0]) check("value0", bus.value[0], e.v0);
    if (e.regwr[1]) check("value1", bus.value[1], e.v1);
    if (e.flush) check("jump_to", bus.jump_to, e.jump);
    if (e.st_req) check("le_size", bus.le_size, e.le_size);
  endtask
  initial begin
    bus.rob_head = '0;
    bus.rob_valid = '0;
    bus.lsq_head = '0;
    bus.retire_stall = 1'b0;
    bus.st_ack = 1'b0;
    bus.rob_head[0] = alu(5'd3, 32'h33);
    bus.rob_head[1] = alu(5'd4, 32'h44);
    bus.rob_valid = 2'b11;
    cyc('0);
    cyc('0);
    reset = 1'b1;
    cyc(wb(2'b11, 2'd2, 5'd3, 32'h33, 32'h44));
    bus.rob_valid = 2'b00;
    cyc('0);
    bus.rob_head[0].ready = 1'b0;
    bus.rob_valid = 2'b11;
    cyc('0);
    bus.rob_head[0] = alu(5'd0, 32'h55);
    bus.rob_valid = 2'b01;
    cyc(wb(2'b01, 2'd1, 5'd0, 32'h0, 32'h0));
    bus.rob_head[0] = alu(5'd3, 32'h33);
    bus.rob_valid = 2'b11;
    bus.retire_stall = 1'b1;
    cyc('0);
    bus.retire_stall = 1'b0;
    st = '0;
    st.ready = 1'b1;
    st.store = 1'b1;
    st.tag = 4'd5;
    bus.lsq_head.tag = 4'd5;
    bus.lsq_head.size = 2'd2;
    bus.rob_head[0] = st;
    bus.rob_head[1] = alu(5'd7, 32'h77);
    x = wb(2'b00, 2'd0, 5'd0, 32'h0, 32'h0);
    x.st_req = 1'b1;
    x.le_size = 32'd4;
    cyc(x);
    cyc(x);
    cyc(x);
    bus.st_ack = 1'b1;
    y = wb(2'b00, 2'd1, 5'd0, 32'h0, 32'h0);
    y.lsq_dec = 1'b1;
    cyc(y);
    bus.st_ack = 1'b0;
    bus.rob_valid = 2'b00;
    cyc('0);
    st.tag = 4'd6;
    bus.rob_head[0] = st;
    bus.rob_valid = 2'b11;
    cyc('0);
    st.tag = 4'd5;
    bus.rob_head[0] = alu(5'd9, 32'h99);
    bus.rob_head[1] = st;
    bus.lsq_head.size = 2'd0;
    x = wb(2'b01, 2'd0, 5'd9, 32'h99, 32'h0);
    x.st_req = 1'b1;
    x.le_size = 32'd1;
    cyc(x);
    bus.rob_valid = 2'b00;
    bus.st_ack = 1'b1;
    y = wb(2'b00, 2'd2, 5'd0, 32'h0, 32'h0);
    y.lsq_dec = 1'b1;
    cyc(y);
    bus.st_ack = 1'b0;
    cyc('0);
    br = '0;
    br.ready = 1'b1;
    br.cjump = 1'b1;
    br.ctrl_bits.flush = 1'b1;
    br.prediction = 1'b1;
    br.pc = 32'h100;
    br.value = 32'h300;
    bus.rob_head[0] = br;
    bus.rob_head[1] = alu(5'd5, 32'h5);
    bus.rob_valid = 2'b11;
    x = wb(2'b00, 2'd1, 5'd0, 32'h0, 32'h0);
    x.flush = 1'b1;
    x.jump = 32'h104;
    cyc(x);
    cyc('0);
    br.prediction = 1'b0;
    bus.rob_head[0] = br;
    x.jump = 32'h300;
    cyc(x);
    bus.rob_valid = 2'b00;
    cyc('0);
    br.ctrl_bits.flush = 1'b0;
    bus.rob_head[0] = br;
    bus.rob_valid = 2'b11;
    cyc(wb(2'b10, 2'd2, 5'd0, 32'h0, 32'h5));
    j = alu(5'd1, 32'h200);
    j.ucjump = 1'b1;
    j.alusrc = 1'b1;
    j.pc = 32'h40;
    bus.rob_head[0] = j;
    x = wb(2'b01, 2'd1, 5'd1, 32'h44, 32'h0);
    x.flush = 1'b1;
    x.jump = 32'h200;
    cyc(x);
    cyc('0);
    bus.rob_valid = 2'b00;
    cyc('0);
    bus.rob_head[0] = st;
    bus.lsq_head.size = 2'd2;
    bus.rob_valid = 2'b01;
    x = wb(2'b00, 2'd0, 5'd0, 32'h0, 32'h0);
    x.st_req = 1'b1;
    x.le_size = 32'd4;
    cyc(x);
    reset = 1'b0;
    bus.rob_valid = 2'b00;
    cyc('0);
    reset = 1'b1;
    bus.st_ack = 1'b1;
    cyc('0);
    bus.st_ack = 1'b0;
    bus.rob_head[0] = alu(5'd3, 32'h33);
    bus.rob_head[1] = alu(5'd4, 32'h44);
    bus.rob_valid = 2'b11;
    repeat (9) cyc(wb(2'b11, 2'd2, 5'd3, 32'h33, 32'h44));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
